// File: rtl/str_arb.sv
// str_arb: round-robin N-to-1 stream arbiter with burst-limited grants
// and a registered output stage.
module str_arb #(
  parameter int VW = 32,
  parameter int N  = 4,
  parameter int BL = 4,
  localparam int GW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_tvalid,
  output logic [N-1:0]    s_tready,
  input  logic [N*VW-1:0] s_tvalue,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [VW-1:0]   m_tvalue,
  output logic            grant_vld,
  output logic [GW-1:0]   grant_id
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        st, st_n;
  logic [GW-1:0] gid_n;
  logic [GW-1:0] last, last_n;
  logic [GW-1:0] pick;
  logic [7:0]    cnt, cnt_n;
  logic          rdy;
  logic          vg;
  logic          acc;
  logic [VW-1:0] sel;
  int            d;
  int            best;

  assign grant_vld = (st == GRANT);
  assign rdy       = ~m_tvalid | m_tready;
  assign acc       = grant_vld & vg & rdy;

  // Priority distance from last: smallest distance among requesters wins.
  always_comb begin
    pick = '0;
    best = N;
    d    = 0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(last) - 1;
      if (d < 0) d = d + N;
      if (s_tvalid[i] && d < best) begin
        best = d;
        pick = GW'(i);
      end
    end
  end

  always_comb begin
    sel      = '0;
    vg       = 1'b0;
    s_tready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == GW'(i)) begin
        sel = s_tvalue[i*VW +: VW];
        vg  = s_tvalid[i];
      end
      s_tready[i] = grant_vld && (grant_id == GW'(i)) && rdy;
    end
  end

  always_comb begin
    st_n   = st;
    gid_n  = grant_id;
    last_n = last;
    cnt_n  = cnt;
    unique case (st)
      IDLE: begin
        if (|s_tvalid) begin
          st_n  = GRANT;
          gid_n = pick;
          cnt_n = '0;
        end
      end
      GRANT: begin
        if (acc) cnt_n = cnt + 8'd1;
        if (!vg || (acc && cnt_n == 8'(BL))) begin
          st_n   = IDLE;
          last_n = grant_id;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      grant_id <= '0;
      last     <= GW'(N-1);
      cnt      <= '0;
      m_tvalid <= 1'b0;
      m_tvalue <= '0;
    end else begin
      st       <= st_n;
      grant_id <= gid_n;
      last     <= last_n;
      cnt      <= cnt_n;
      // Output stage drains independently of the grant state.
      if (acc) begin
        m_tvalid <= 1'b1;
        m_tvalue <= sel;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_str_arb.sv
// tb_str_arb: vector table, hand sequences and a randomized
// scoreboard run against a behavioural arbiter model.
module tb_str_arb;

  localparam int VW = 32;
  localparam int N  = 4;
  localparam int BL = 4;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N*VW-1:0] s_tvalue;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [VW-1:0]   m_tvalue;
  logic            grant_vld;
  logic [GW-1:0]   grant_id;
  logic [VW-1:0]   sval [N];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign s_tvalue = {sval[3], sval[2], sval[1], sval[0]};

  str_arb #(.VW(VW), .N(N), .BL(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tvalue  (s_tvalue),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tvalue  (m_tvalue),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model state
  logic          mgv;
  logic [1:0]    mgid;
  int            last;
  int            beats;
  logic          mmv;
  logic [31:0]   mmval;
  logic          p_arb, p_rel, p_acc, p_otx;
  logic [1:0]    p_eid;
  logic [31:0]   p_sv;
  logic [N-1:0]  acc_flag;
  int            seq [N];
  int            oseq [N];
  int            nin, nout, cyc;
  int            mode;
  int            obs_src [$];
  int            obs_cyc [$];

  function automatic int rr_pick(input int lst, input logic [N-1:0] v);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (lst + k) % N;
      if (v[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic model_init();
    mgv = 0; mgid = 0; last = N-1; beats = 0;
    mmv = 0; mmval = 0;
    p_arb = 0; p_rel = 0; p_acc = 0; p_otx = 0;
    p_eid = 0; p_sv = 0; acc_flag = '0;
    nin = 0; nout = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      oseq[i] = 0;
    end
    obs_src.delete();
    obs_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = '0;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) sval[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_init();
  endtask

  // Sampled at negedge: applies last cycle's events, compares, then
  // derives the events the coming edge will produce.
  task automatic monitor();
    logic [N-1:0] erdy;
    logic         vg, acc;
    int           src, sq;
    if (p_arb) begin
      mgv = 1; mgid = p_eid; beats = 0;
    end else if (p_rel) begin
      mgv = 0; last = int'(mgid);
    end
    if (p_acc) begin
      mmv = 1; mmval = p_sv;
    end else if (p_otx) begin
      mmv = 0;
    end
    chk("grant_vld", grant_vld, mgv);
    chk("grant_id", grant_id, mgid);
    chk("m_tvalid", m_tvalid, mmv);
    chk("m_tvalue", m_tvalue, mmval);
    erdy = '0;
    if (mgv) erdy[mgid] = !mmv || m_tready;
    chk("s_tready", s_tready, erdy);
    vg  = s_tvalid[mgid];
    acc = mgv && vg && (!mmv || m_tready);
    acc_flag = '0;
    p_acc = acc;
    if (acc) begin
      acc_flag[mgid] = 1'b1;
      beats++;
      nin++;
      p_sv = sval[mgid];
    end
    p_rel = mgv && (!vg || (acc && beats == BL));
    p_otx = m_tvalid && m_tready;
    if (p_otx) begin
      src = int'(m_tvalue[31:24]);
      sq  = int'(m_tvalue[23:0]);
      chk("out_src_ok", src < N, 1);
      if (src < N) begin
        chk($sformatf("out_seq_s%0d", src), sq, oseq[src]);
        oseq[src]++;
      end
      nout++;
      obs_src.push_back(src);
      obs_cyc.push_back(cyc);
    end
    p_arb = !mgv && (|s_tvalid);
    if (p_arb) p_eid = 2'(rr_pick(last, s_tvalid));
    cyc++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++)
      if (acc_flag[i]) seq[i]++;
    case (mode)
      0: begin
        for (int i = 0; i < N; i++) begin
          if (s_tvalid[i]) s_tvalid[i] = ($urandom_range(15) != 0);
          else             s_tvalid[i] = ($urandom_range(1) != 0);
        end
        m_tready = ($urandom_range(3) != 0);
      end
      1: begin s_tvalid = '1; m_tready = 1'b1; end
      default: begin s_tvalid = '0; m_tready = 1'b1; end
    endcase
    for (int i = 0; i < N; i++) sval[i] = {8'(i), 24'(seq[i])};
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic        rdy;
    logic        gv;
    logic [1:0]  gid;
    logic        mv;
    logic [31:0] mval;
    logic [3:0]  srdy;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 32'h00, 4'b0100};
    tbl[1]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 32'hA5, 4'b0100};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 32'hA5, 4'b0000};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 32'hA5, 4'b0000};
    tbl[4]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 32'hA5, 4'b0010};
    tbl[5]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 32'h22, 4'b0010};
    tbl[6]  = '{4'b0110, 1'b1, 1'b1, 2'd1, 1'b1, 32'h22, 4'b0010};
    tbl[7]  = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 4'b0000};
    tbl[8]  = '{4'b0110, 1'b1, 1'b1, 2'd2, 1'b0, 32'h22, 4'b0100};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 4'b0000};
    tbl[10] = '{4'b1000, 1'b0, 1'b1, 2'd3, 1'b0, 32'h22, 4'b1000};
    tbl[11] = '{4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 32'h33, 4'b0000};
    tbl[12] = '{4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 32'h33, 4'b0000};
    tbl[13] = '{4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 32'h33, 4'b1000};

    mode = 2;
    do_reset();
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tvalue", m_tvalue, 0);
    chk("rst_s_tready", s_tready, 0);

    sval[0] = 32'h11; sval[1] = 32'h22;
    sval[2] = 32'hA5; sval[3] = 32'h33;
    for (int i = 0; i < 14; i++) begin
      s_tvalid = tbl[i].vld;
      m_tready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_gv", i), grant_vld, tbl[i].gv);
      chk($sformatf("v%0d_gid", i), grant_id, tbl[i].gid);
      chk($sformatf("v%0d_mv", i), m_tvalid, tbl[i].mv);
      chk($sformatf("v%0d_mval", i), m_tvalue, tbl[i].mval);
      chk($sformatf("v%0d_srdy", i), s_tready, tbl[i].srdy);
    end

    // Reset mid-burst with a pending beat; last must return to N-1.
    do_reset();
    m_tready = 1'b0;
    s_tvalid = 4'b0100;
    @(posedge clk); #1;
    s_tvalid = 4'b0000;
    @(posedge clk); #1;
    chk("mb_released", grant_vld, 0);
    s_tvalid = 4'b0010;
    @(posedge clk); #1;
    chk("mb_gid1", grant_id, 1);
    @(posedge clk); #1;
    chk("mb_pending", m_tvalid, 1);
    chk("mb_stall_rdy", s_tready, 0);
    rst = 1'b1;
    s_tvalid = 4'b1111;
    @(posedge clk); #1;
    chk("mb_rst_mv", m_tvalid, 0);
    chk("mb_rst_gv", grant_vld, 0);
    chk("mb_rst_srdy", s_tready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mb_after_gv", grant_vld, 1);
    chk("mb_after_gid", grant_id, 0);

    // Round-robin with all sources continuously valid.
    do_reset();
    mode = 1;
    drive();
    for (int c = 0; c < 80 && obs_src.size() < 20; c++) step();
    chk("rr_beats", obs_src.size() >= 20, 1);
    for (int i = 0; i < 20 && i < obs_src.size(); i++)
      chk($sformatf("rr_src%0d", i), obs_src[i], (i / 4) % 4);
    if (obs_cyc.size() >= 5) begin
      chk("rr_gap_in", obs_cyc[1] - obs_cyc[0], 1);
      chk("rr_gap_between", obs_cyc[4] - obs_cyc[3], 2);
    end

    // Random scoreboard run.
    do_reset();
    mode = 0;
    drive();
    for (int c = 0; c < 10000; c++) step();
    mode = 2;
    drive();
    for (int c = 0; c < 20; c++) step();
    chk("rand_in_eq_out", nout, nin);
    chk("rand_activity", nin > 1000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
